// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: steers the HPS ioctl byte stream into four ROM regions,
// captures the title number and holds the game core in reset until a verified load.
module rom_load_ctrl #(
    parameter int unsigned R1_BASE  = 'h08000,
    parameter int unsigned R2_BASE  = 'h10000,
    parameter int unsigned R3_BASE  = 'h18000,
    parameter int unsigned ROM_SIZE = 'h1A000,
    parameter int unsigned RST_HOLD = 1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic [3:0]  rom_sel,
    output logic [17:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [3:0]  tno,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_err,
    output logic [15:0] checksum
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_dl_q;
    logic [3:0]          r_rom_sel;
    logic [17:0]         r_rom_addr;
    logic [7:0]          r_rom_data;
    logic [3:0]          r_tno;
    logic                r_core_reset;
    logic                r_load_ok;
    logic                r_load_err;
    logic [15:0]         r_checksum;
    logic [24:0]         r_byte_cnt;
    logic                r_ovf;
    logic [HOLD_W-1:0]   r_hold_cnt;

    logic                w_rise;
    logic                w_fall;
    logic                w_accept;
    logic                w_in_range;
    logic                w_rom_wr;
    logic                w_ovf_wr;
    logic                w_tno_wr;
    logic                w_check_ok;
    logic [3:0]          w_sel;
    logic [17:0]         w_base;
    logic [17:0]         w_off;
    logic [24:0]         w_cnt_base;
    logic [15:0]         w_sum_base;

    assign w_rise = ioctl_download & ~r_dl_q;
    assign w_fall = ~ioctl_download & r_dl_q;

    // The rise cycle and the fall cycle both still take a byte: the rise through
    // w_rise, the fall because the state is still LOAD during that cycle.
    assign w_accept   = ioctl_wr & (w_rise | (r_state == S_LOAD));
    assign w_in_range = ioctl_addr < 25'(ROM_SIZE);
    assign w_rom_wr   = w_accept & (ioctl_index == 8'd0) & w_in_range;
    assign w_ovf_wr   = w_accept & (ioctl_index == 8'd0) & ~w_in_range;
    assign w_tno_wr   = w_accept & (ioctl_index == 8'd1);
    assign w_check_ok = (r_byte_cnt == 25'(ROM_SIZE)) & ~r_ovf;

    // A new download restarts the byte count and checksum from zero, with the
    // rise-cycle byte (if any) added on top.
    assign w_cnt_base = w_rise ? 25'd0 : r_byte_cnt;
    assign w_sum_base = w_rise ? 16'd0 : r_checksum;

    // NOTE: every variable in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_sel  = 4'b1000;
        w_base = 18'(R3_BASE);
        if (ioctl_addr < 25'(R1_BASE)) begin
            w_sel  = 4'b0001;
            w_base = 18'd0;
        end else if (ioctl_addr < 25'(R2_BASE)) begin
            w_sel  = 4'b0010;
            w_base = 18'(R1_BASE);
        end else if (ioctl_addr < 25'(R3_BASE)) begin
            w_sel  = 4'b0100;
            w_base = 18'(R2_BASE);
        end
    end

    // Offset modulo 2^18 equals the full difference truncated to 18 bits.
    assign w_off = ioctl_addr[17:0] - w_base;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD:  if (w_fall) w_next_state = S_CHECK;
            S_CHECK: w_next_state = w_check_ok ? S_HOLD : S_ERR;
            S_HOLD:  if (r_hold_cnt == HOLD_W'(1)) w_next_state = S_RUN;
            default: w_next_state = r_state;
        endcase
        if (w_rise) begin
            w_next_state = S_LOAD;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_dl_q       <= 1'b0;
            r_core_reset <= 1'b1;
            r_hold_cnt   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_dl_q       <= ioctl_download;
            r_core_reset <= (w_next_state != S_RUN);
            if (r_state == S_CHECK) begin
                r_hold_cnt <= HOLD_W'(RST_HOLD);
            end else if ((r_state == S_HOLD) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_sel  <= 4'b0;
            r_rom_addr <= 18'd0;
            r_rom_data <= 8'd0;
            r_tno      <= 4'd0;
        end else begin
            r_rom_sel <= w_rom_wr ? w_sel : 4'b0;
            if (w_rom_wr) begin
                r_rom_addr <= w_off;
                r_rom_data <= ioctl_dout;
            end
            if (w_tno_wr) begin
                r_tno <= ioctl_dout[3:0];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_cnt <= 25'd0;
            r_checksum <= 16'd0;
            r_ovf      <= 1'b0;
            r_load_ok  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_byte_cnt <= w_rom_wr ? w_cnt_base + 25'd1 : w_cnt_base;
            r_checksum <= w_rom_wr ? w_sum_base + {8'd0, ioctl_dout} : w_sum_base;
            if (w_rise) begin
                r_ovf      <= w_ovf_wr;
                r_load_ok  <= 1'b0;
                r_load_err <= 1'b0;
            end else begin
                if (w_ovf_wr) begin
                    r_ovf <= 1'b1;
                end
                if (r_state == S_CHECK) begin
                    r_load_ok  <= w_check_ok;
                    r_load_err <= ~w_check_ok;
                end
            end
        end
    end

    assign rom_sel    = r_rom_sel;
    assign rom_addr   = r_rom_addr;
    assign rom_data   = r_rom_data;
    assign tno        = r_tno;
    assign core_reset = r_core_reset;
    assign load_ok    = r_load_ok;
    assign load_err   = r_load_err;
    assign checksum   = r_checksum;

endmodule
